// File: rtl/mem_stage.sv
// Memory-access stage: turns execute results into register write-backs and
// runs load/store transactions on a req/ack data-memory port with a timeout.
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk_mem,
    input  logic        rst_mem,
    input  logic [15:0] alu_out,
    input  logic [15:0] imm_1,
    input  logic [3:0]  op_code_1,
    input  logic [2:0]  dr_addr_1,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        mem_err,
    output logic        dbg_state
);

    // Handshake: mem_req rises on the capture edge and holds, with mem_we,
    // mem_addr and mem_wdata stable, until the edge that samples mem_ack high
    // (one-cycle strobe) or the timeout edge; mem_ack is ignored while idle.

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_wb_en;
    logic [2:0]  r_wb_addr;
    logic [15:0] r_wb_data;
    logic        r_mem_err;
    logic [7:0]  r_cnt;
    logic        r_is_ld;
    logic [2:0]  r_dest;

    state_t      w_state_nxt;
    logic        w_mem_req_nxt;
    logic        w_mem_we_nxt;
    logic [15:0] w_mem_addr_nxt;
    logic [15:0] w_mem_wdata_nxt;
    logic        w_wb_en_nxt;
    logic [2:0]  w_wb_addr_nxt;
    logic [15:0] w_wb_data_nxt;
    logic        w_mem_err_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_is_ld_nxt;
    logic [2:0]  w_dest_nxt;

    logic        w_op_ld;
    logic        w_op_st;
    logic        w_op_wb;

    assign w_op_ld = (op_code_1 == 4'h8);
    assign w_op_st = (op_code_1 == 4'h9);
    assign w_op_wb = (op_code_1 >= 4'h1) && (op_code_1 <= 4'h7);

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_wb_en_nxt     = 1'b0;
        w_wb_addr_nxt   = r_wb_addr;
        w_wb_data_nxt   = r_wb_data;
        w_mem_err_nxt   = r_mem_err;
        w_cnt_nxt       = r_cnt;
        w_is_ld_nxt     = r_is_ld;
        w_dest_nxt      = r_dest;

        case (r_state)
            IDLE: begin
                if (w_op_ld || w_op_st) begin
                    w_state_nxt    = BUSY;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = w_op_st;
                    w_mem_addr_nxt = w_op_st ? imm_1 : alu_out;
                    if (w_op_st) begin
                        w_mem_wdata_nxt = alu_out;
                    end
                    w_cnt_nxt   = 8'd0;
                    w_is_ld_nxt = w_op_ld;
                    w_dest_nxt  = dr_addr_1;
                end else begin
                    w_wb_en_nxt   = w_op_wb;
                    w_wb_addr_nxt = dr_addr_1;
                    w_wb_data_nxt = (op_code_1 == 4'h7) ? imm_1 : alu_out;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt + 8'd1;
                // Ack wins over a coinciding timeout.
                if (mem_ack) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    if (r_is_ld) begin
                        w_wb_en_nxt   = 1'b1;
                        w_wb_addr_nxt = r_dest;
                        w_wb_data_nxt = mem_rdata;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_mem_err_nxt = 1'b1;
                    if (r_is_ld) begin
                        w_wb_en_nxt   = 1'b1;
                        w_wb_addr_nxt = r_dest;
                        w_wb_data_nxt = 16'h0000;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_mem) begin
        if (rst_mem) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= 3'd0;
            r_wb_data   <= 16'h0000;
            r_mem_err   <= 1'b0;
            r_cnt       <= 8'd0;
            r_is_ld     <= 1'b0;
            r_dest      <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_wb_en     <= w_wb_en_nxt;
            r_wb_addr   <= w_wb_addr_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_mem_err   <= w_mem_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_ld     <= w_is_ld_nxt;
            r_dest      <= w_dest_nxt;
        end
    end

    assign stall     = (r_state == BUSY);
    assign dbg_state = r_state;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomised bench for mem_stage; write-backs are matched
// against an expected queue filled as instructions are driven.
module tb_mem_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_out;
    logic [15:0] imm_1;
    logic [3:0]  op_code_1;
    logic [2:0]  dr_addr_1;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        mem_err;
    logic        dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [18:0] exp_q[$];

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk_mem   (clk),
        .rst_mem   (rst),
        .alu_out   (alu_out),
        .imm_1     (imm_1),
        .op_code_1 (op_code_1),
        .dr_addr_1 (dr_addr_1),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .mem_err   (mem_err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; any write-back pulse is matched against the scoreboard.
    task automatic step();
        logic [18:0] e;
        @(posedge clk);
        #1;
        if (wb_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'(wb_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb", 32'({wb_addr, wb_data}), 32'(e));
            end
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] alu,
                         input logic [15:0] imm, input logic [2:0] dr);
        op_code_1 = op;
        alu_out   = alu;
        imm_1     = imm;
        dr_addr_1 = dr;
    endtask

    task automatic push_wb(input logic [2:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Called in the first BUSY cycle; acks in BUSY cycle ack_cycle (0 = never).
    task automatic run_busy(input int ack_cycle, input logic [15:0] rdata, output int n);
        n = 0;
        mem_rdata = rdata;
        for (int i = 0; i < 40; i++) begin
            if (stall !== 1'b1) break;
            n++;
            mem_ack = (n == ack_cycle);
            step();
        end
        mem_ack = 1'b0;
        check("busy_bounded", 32'(stall), 32'd0);
    endtask

    initial begin
        int          n;
        int          k;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  d;

        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        drive(4'h0, 16'h0000, 16'h0000, 3'd0);
        step();
        step();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_wb", 32'({wb_addr, wb_data}), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        check("rst_addr", 32'({mem_addr, mem_wdata}), 32'd0);
        rst = 1'b0;

        // ADD then LI then NOP
        drive(4'h1, 16'h1234, 16'h0000, 3'd3);
        push_wb(3'd3, 16'h1234);
        step();
        check("add_wb_en", 32'(wb_en), 32'd1);
        check("add_stall", 32'(stall), 32'd0);
        drive(4'h7, 16'h0000, 16'hBEEF, 3'd5);
        push_wb(3'd5, 16'hBEEF);
        step();
        check("li_wb_en", 32'(wb_en), 32'd1);
        check("li_stall", 32'(stall), 32'd0);
        drive(4'h0, 16'h0000, 16'h0000, 3'd0);
        step();
        check("nop_wb_en", 32'(wb_en), 32'd0);

        // LD acked in 3rd BUSY cycle, ADD held behind it
        drive(4'h8, 16'h0040, 16'h0000, 3'd2);
        push_wb(3'd2, 16'h00AA);
        step();
        check("ld_req", 32'(mem_req), 32'd1);
        check("ld_we", 32'(mem_we), 32'd0);
        check("ld_addr", 32'(mem_addr), 32'h0040);
        check("ld_wb_en_busy", 32'(wb_en), 32'd0);
        drive(4'h1, 16'h0777, 16'h0000, 3'd4);
        push_wb(3'd4, 16'h0777);
        run_busy(3, 16'h00AA, n);
        check("ld_stall_cycles", 32'(n), 32'd3);
        check("ld_wb_en", 32'(wb_en), 32'd1);
        check("ld_req_drop", 32'(mem_req), 32'd0);
        step();
        check("held_add_wb_en", 32'(wb_en), 32'd1);
        drive(4'h0, 16'h0000, 16'h0000, 3'd0);
        step();
        check("held_add_once", 32'(wb_en), 32'd0);

        // ST acked in 1st BUSY cycle
        drive(4'h9, 16'h5555, 16'h0100, 3'd1);
        step();
        check("st_req", 32'(mem_req), 32'd1);
        check("st_we", 32'(mem_we), 32'd1);
        check("st_addr", 32'(mem_addr), 32'h0100);
        check("st_wdata", 32'(mem_wdata), 32'h5555);
        drive(4'h0, 16'h0000, 16'h0000, 3'd0);
        run_busy(1, 16'hDEAD, n);
        check("st_stall_cycles", 32'(n), 32'd1);
        check("st_no_wb", 32'(wb_en), 32'd0);
        step();
        check("st_no_wb_late", 32'(wb_en), 32'd0);

        // Random non-memory ops
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(1, 7));
            a = 16'($urandom);
            b = 16'($urandom);
            d = 3'($urandom_range(0, 7));
            drive(op, a, b, d);
            push_wb(d, (op == 4'h7) ? b : a);
            step();
            check("rnd_wb_en", 32'(wb_en), 32'd1);
        end

        // Random loads with random ack latency
        for (int i = 0; i < 3; i++) begin
            k = $urandom_range(1, 3);
            a = 16'($urandom);
            b = 16'($urandom);
            d = 3'($urandom_range(0, 7));
            drive(4'h8, a, 16'h0000, d);
            push_wb(d, b);
            step();
            check("rnd_ld_addr", 32'(mem_addr), 32'(a));
            drive(4'h0, 16'h0000, 16'h0000, 3'd0);
            run_busy(k, b, n);
            check("rnd_ld_stall", 32'(n), 32'(k));
        end

        // LD timeout, then a stray ack while idle
        drive(4'h8, 16'h0080, 16'h0000, 3'd6);
        push_wb(3'd6, 16'h0000);
        step();
        check("tmo_err_before", 32'(mem_err), 32'd0);
        drive(4'h0, 16'h0000, 16'h0000, 3'd0);
        run_busy(0, 16'hFFFF, n);
        check("tmo_stall_cycles", 32'(n), 32'(TMO));
        check("tmo_err", 32'(mem_err), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("idle_ack_wb", 32'(wb_en), 32'd0);
        check("idle_ack_stall", 32'(stall), 32'd0);
        check("idle_ack_req", 32'(mem_req), 32'd0);
        step();
        check("tmo_err_sticky", 32'(mem_err), 32'd1);

        // Reset in 2nd BUSY cycle of an LD
        drive(4'h8, 16'h0010, 16'h0000, 3'd7);
        step();
        drive(4'h0, 16'h0000, 16'h0000, 3'd0);
        step();
        check("mid_busy_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_stall", 32'(stall), 32'd0);
        check("mrst_req", 32'({mem_req, mem_we}), 32'd0);
        check("mrst_mem", 32'({mem_addr, mem_wdata}), 32'd0);
        check("mrst_wb", 32'({wb_en, wb_addr, wb_data}), 32'd0);
        check("mrst_err", 32'(mem_err), 32'd0);
        drive(4'h1, 16'hA5A5, 16'h0000, 3'd1);
        push_wb(3'd1, 16'hA5A5);
        step();
        check("post_rst_add", 32'(wb_en), 32'd1);
        drive(4'h0, 16'h0000, 16'h0000, 3'd0);
        step();
        step();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
